// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 7;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_checker.sv
// Protocol invariants of the fetch stage; simulation-only companion of the top.
module fetch_checker (
    input logic       clk,
    input logic       rst_n,
    input logic       rvalid,
    input logic       push,
    input logic [1:0] fifo_cnt,
    input logic [1:0] out_cnt,
    input logic [1:0] pcq_cnt
);

    push_into_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (fifo_cnt != 2'd2));

    resp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
        rvalid |-> (pcq_cnt != 2'd0));

    out_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        out_cnt <= 2'd2);

endmodule

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with synchronous flush; the entry type is a parameter so the
// same block serves as the instruction buffer and the in-flight PC tag queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  ENTRY_T     push_data,
    input  logic       pop,
    output logic [1:0] count,
    output ENTRY_T     head
);

    ENTRY_T     mem_r [2];
    logic       rd_ptr_r;
    logic       wr_ptr_r;
    logic [1:0] cnt_r;
    logic [1:0] cnt_next_s;
    logic       do_push_s;
    logic       do_pop_s;

    assign do_push_s = push && (cnt_r != 2'd2);
    assign do_pop_s  = pop && (cnt_r != 2'd0);
    assign count     = cnt_r;
    assign head      = mem_r[rd_ptr_r];

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_next_s = cnt_r;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_next_s = cnt_r + 2'd1;
            2'b01:   cnt_next_s = cnt_r - 2'd1;
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Storage and pointers; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited memory requests, buffers
// responses with their PCs and hands them to decode over valid/ready.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                imem_req_o,
    output logic [XLEN-1:0]     imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [XLEN-1:0]     imem_rdata_i,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [XLEN-1:0]     instr_o,
    output logic [XLEN-1:0]     instr_pc_o,
    output logic [OPCODE_W-1:0] opcode_o
);

    localparam logic [2:0] CREDIT_LIMIT = 3'(MAX_OUTSTANDING);

    fetch_state_e    state_r, state_next_s;
    logic [XLEN-1:0] fetch_pc_r, fetch_pc_next_s;
    logic [1:0]      out_cnt_r, out_cnt_next_s;
    logic [1:0]      disc_cnt_r, disc_cnt_next_s;
    logic [1:0]      fifo_cnt_s;
    logic [1:0]      pcq_cnt_s;
    fetch_entry_t    fifo_head_s;
    fetch_entry_t    fifo_push_data_s;
    logic [XLEN-1:0] pcq_head_s;
    logic            credit_ok_s;
    logic            grant_s;
    logic            drop_s;
    logic            push_s;
    logic            pop_s;

    // Outstanding requests plus buffered entries never exceed the FIFO depth,
    // so a returning response always has room.
    assign credit_ok_s   = ({1'b0, out_cnt_r} + {1'b0, fifo_cnt_s}) < CREDIT_LIMIT;
    assign imem_req_o    = (state_r == RUN) && !redirect_i && credit_ok_s;
    assign imem_addr_o   = fetch_pc_r;
    assign grant_s       = imem_req_o && imem_gnt_i;
    assign drop_s        = imem_rvalid_i && (disc_cnt_r != 2'd0);
    assign push_s        = imem_rvalid_i && !drop_s;
    assign instr_valid_o = (fifo_cnt_s != 2'd0);
    assign pop_s         = instr_valid_o && instr_ready_i;

    assign fifo_push_data_s = '{instr: imem_rdata_i, pc: pcq_head_s};
    assign instr_o          = instr_valid_o ? fifo_head_s.instr : NOP_INSTR;
    assign instr_pc_o       = instr_valid_o ? fifo_head_s.pc : 32'h0000_0000;
    assign opcode_o         = instr_o[OPCODE_W-1:0];

    // BOOT holds off requests for exactly one cycle after reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT:    state_next_s = RUN;
            RUN:     state_next_s = RUN;
            default: state_next_s = BOOT;
        endcase
    end

    // PC and counter next values; a redirect re-arms discards for every
    // request still in flight after this cycle's response.
    always_comb begin
        fetch_pc_next_s = fetch_pc_r;
        out_cnt_next_s  = out_cnt_r;
        disc_cnt_next_s = disc_cnt_r;

        if (redirect_i) begin
            fetch_pc_next_s = align_word(redirect_pc_i);
        end else if (grant_s) begin
            fetch_pc_next_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end

        case ({grant_s, imem_rvalid_i})
            2'b10:   out_cnt_next_s = out_cnt_r + 2'd1;
            2'b01:   out_cnt_next_s = out_cnt_r - 2'd1;
            default: out_cnt_next_s = out_cnt_r;
        endcase

        if (redirect_i) begin
            disc_cnt_next_s = out_cnt_r - {1'b0, imem_rvalid_i};
        end else if (drop_s) begin
            disc_cnt_next_s = disc_cnt_r - 2'd1;
        end else begin
            disc_cnt_next_s = disc_cnt_r;
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= BOOT;
            fetch_pc_r <= RESET_PC;
            out_cnt_r  <= 2'd0;
            disc_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            out_cnt_r  <= out_cnt_next_s;
            disc_cnt_r <= disc_cnt_next_s;
        end
    end

    fetch_fifo #(.ENTRY_T(fetch_entry_t)) instr_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (redirect_i),
        .push      (push_s),
        .push_data (fifo_push_data_s),
        .pop       (pop_s),
        .count     (fifo_cnt_s),
        .head      (fifo_head_s)
    );

    // Tags survive redirects: discarded responses still consume their entry.
    fetch_fifo #(.ENTRY_T(logic [XLEN-1:0])) pc_queue (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (1'b0),
        .push      (grant_s),
        .push_data (fetch_pc_r),
        .pop       (imem_rvalid_i),
        .count     (pcq_cnt_s),
        .head      (pcq_head_s)
    );

    fetch_checker checker_inst (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .rvalid   (imem_rvalid_i),
        .push     (push_s),
        .fifo_cnt (fifo_cnt_s),
        .out_cnt  (out_cnt_r),
        .pcq_cnt  (pcq_cnt_s)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small in-order memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    int          n_cmp;
    int          n_err;
    int          grants;
    int          delivered;
    logic [31:0] exp_pc;
    logic        hold_rsp;
    logic        drained;
    logic [31:0] pend[$];

    instr_fetch_unit #(.RESET_PC(32'h0000_0100), .MAX_OUTSTANDING(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .opcode_o      (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return {a[29:0], 2'b11};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // One clock: record handshakes at the falling edge, then drive the memory response.
    task automatic step();
        @(negedge clk);
        if (instr_valid && instr_ready) begin
            check_eq("deliver_pc", instr_pc, exp_pc);
            check_eq("deliver_instr", instr, mk_instr(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (imem_req && imem_gnt) begin
            pend.push_back(imem_addr);
            grants++;
        end
        if (imem_rvalid) void'(pend.pop_front());
        @(posedge clk);
        #1;
        imem_rvalid = !hold_rsp && (pend.size() != 0);
        imem_rdata  = (pend.size() != 0) ? mk_instr(pend[0]) : 32'h0;
    endtask

    task automatic chk_reset_outputs();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0000_0100);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_pc", instr_pc, 32'h0);
        check_eq("rst_opcode", {25'd0, opcode}, 32'h13);
    endtask

    task automatic drain();
        imem_gnt    = 1'b0;
        instr_ready = 1'b1;
        drained     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            #1;
            if (pend.size() == 0 && !instr_valid && !imem_rvalid) begin
                drained = 1'b1;
                break;
            end
        end
        check_eq("drain", {31'd0, drained}, 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; grants = 0; delivered = 0;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0; hold_rsp = 1'b0;
        exp_pc = 32'h0000_0100;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();

        // Cycle 0 (BOOT), then first request, 4-cycle grant stall on 0x104.
        rst_n = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
        #1;
        check_eq("boot_req", {31'd0, imem_req}, 32'd0);
        step(); #1;
        check_eq("c1_req", {31'd0, imem_req}, 32'd1);
        check_eq("c1_addr", imem_addr, 32'h0000_0100);
        step(); imem_gnt = 1'b0; #1;
        check_eq("c2_req", {31'd0, imem_req}, 32'd1);
        check_eq("c2_addr", imem_addr, 32'h0000_0104);
        check_eq("c2_valid", {31'd0, instr_valid}, 32'd0);
        step(); #1;
        check_eq("c3_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("c3_pc", instr_pc, 32'h0000_0100);
        check_eq("c3_instr", instr, 32'h0000_0403);
        check_eq("c3_opcode", {25'd0, opcode}, 32'h03);
        check_eq("c3_addr", imem_addr, 32'h0000_0104);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            check_eq("stall_req", {31'd0, imem_req}, 32'd1);
            check_eq("stall_addr", imem_addr, 32'h0000_0104);
        end
        step(); imem_gnt = 1'b1;
        repeat (12) step();

        // Decode back-pressure: credit caps buffered plus in-flight at two.
        instr_ready = 1'b0;
        repeat (10) step();
        #1;
        check_eq("bp_req", {31'd0, imem_req}, 32'd0);
        check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("bp_credit", 32'(grants - delivered), 32'd2);
        instr_ready = 1'b1;
        repeat (12) step();

        // Two requests in flight, redirect to 0x2002: both responses dropped.
        drain();
        hold_rsp = 1'b1; imem_gnt = 1'b1;
        step(); step(); #1;
        check_eq("inflight_req", {31'd0, imem_req}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_2002; exp_pc = 32'h0000_2000;
        step(); redirect = 1'b0; hold_rsp = 1'b0; #1;
        check_eq("rd1_addr", imem_addr, 32'h0000_2000);
        check_eq("rd1_valid", {31'd0, instr_valid}, 32'd0);
        step(); step(); #1;
        check_eq("rd3_req", {31'd0, imem_req}, 32'd1);
        check_eq("rd3_addr", imem_addr, 32'h0000_2000);
        step(); step(); #1;
        check_eq("rd5_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("rd5_pc", instr_pc, 32'h0000_2000);
        check_eq("rd5_instr", instr, 32'h0000_8003);
        repeat (6) step();

        // Redirect while the FIFO holds an entry and a response arrives.
        drain();
        instr_ready = 1'b0; imem_gnt = 1'b1;
        step(); step(); #1;
        check_eq("rv_req", {31'd0, imem_req}, 32'd0);
        check_eq("rv_valid", {31'd0, instr_valid}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_3000; exp_pc = 32'h0000_3000;
        step(); redirect = 1'b0; instr_ready = 1'b1; #1;
        check_eq("rv1_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rv1_req", {31'd0, imem_req}, 32'd1);
        check_eq("rv1_addr", imem_addr, 32'h0000_3000);
        step(); #1;
        check_eq("rv2_valid", {31'd0, instr_valid}, 32'd0);
        step(); #1;
        check_eq("rv3_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("rv3_pc", instr_pc, 32'h0000_3000);
        check_eq("rv3_instr", instr, 32'h0000_C003);
        repeat (4) step();

        // Asynchronous reset mid-stream, then a redirect during BOOT.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        pend.delete();
        imem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_4001;
        #1;
        check_eq("boot_redir_req", {31'd0, imem_req}, 32'd0);
        step(); redirect = 1'b0; exp_pc = 32'h0000_4000; #1;
        check_eq("boot_redir_req1", {31'd0, imem_req}, 32'd1);
        check_eq("boot_redir_addr", imem_addr, 32'h0000_4000);
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
